// File: rtl/flash_ctrl_pkg.sv
// Shared definitions for the user-flash sequencer: op codes, FSM states,
// CSR addresses, status bit positions and control-register words.
package flash_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ERASE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        UNLOCK,
        WR_ISSUE,
        ER_CTRL,
        POLL,
        LOCK,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_GAP,
        PH_READ,
        PH_SAMPLE
    } poll_phase_e;

    localparam logic CSR_STATUS  = 1'b0;
    localparam logic CSR_CONTROL = 1'b1;

    localparam int ST_BUSY_LO = 0;
    localparam int ST_BUSY_HI = 1;
    localparam int ST_RD_OK   = 2;
    localparam int ST_WR_OK   = 3;
    localparam int ST_ER_OK   = 4;

    localparam logic [31:0] CTRL_LOCK   = 32'hFFFF_FFFF;
    localparam logic [31:0] CTRL_UNLOCK = {4'hF, 5'b00000, 3'b111, 20'hFFFFF};

    function automatic logic [31:0] erase_ctrl(input logic [2:0] sector);
        return {4'hF, 5'b00000, sector, 20'hFFFFF};
    endfunction

    // Only sectors 1..5 exist on the user flash.
    function automatic logic sector_valid(input logic [2:0] sector);
        return (sector >= 3'd1) && (sector <= 3'd5);
    endfunction

endpackage

// File: rtl/flash_status_poller.sv
// Status polling for write/erase: spaced CSR status reads, busy decode,
// success-bit selection and an overall timeout.
module flash_status_poller
    import flash_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TO_W           = 21,
    parameter int POLL_GAP       = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        active,
    input  logic        is_erase,
    input  logic [31:0] csr_readdata,
    output logic        csr_read,
    output logic        done,
    output logic        ok,
    output logic        timeout
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
    localparam poll_phase_e FIRST_PHASE = (POLL_GAP == 0) ? PH_READ : PH_GAP;

    poll_phase_e      phase_reg, phase_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic [TO_W-1:0]  to_reg, to_next;
    logic             busy;
    logic             unused_bits;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg <= PH_GAP;
            gap_reg   <= '0;
            to_reg    <= '0;
        end else begin
            phase_reg <= phase_next;
            gap_reg   <= gap_next;
            to_reg    <= to_next;
        end
    end

    always_comb begin
        phase_next = phase_reg;
        gap_next   = gap_reg;
        to_next    = to_reg;
        if (start) begin
            phase_next = FIRST_PHASE;
            gap_next   = '0;
            to_next    = '0;
        end else if (active) begin
            if (!timeout)
                to_next = to_reg + 1'b1;
            case (phase_reg)
                PH_GAP: begin
                    if (gap_reg == GAP_LAST)
                        phase_next = PH_READ;
                    else
                        gap_next = gap_reg + 1'b1;
                end
                PH_READ:   phase_next = PH_SAMPLE;
                PH_SAMPLE: begin
                    if (busy) begin
                        phase_next = FIRST_PHASE;
                        gap_next   = '0;
                    end
                end
                default:   phase_next = FIRST_PHASE;
            endcase
        end
    end

    // Status data is only meaningful in the sample phase, one cycle after the read.
    assign busy        = |csr_readdata[ST_BUSY_HI:ST_BUSY_LO];
    assign done        = active && (phase_reg == PH_SAMPLE) && !busy;
    assign ok          = is_erase ? csr_readdata[ST_ER_OK] : csr_readdata[ST_WR_OK];
    assign timeout     = active && (to_reg == TO_W'(TIMEOUT_CYCLES));
    assign csr_read    = active && (phase_reg == PH_READ) && !timeout;
    assign unused_bits = ^{csr_readdata[31:5], csr_readdata[ST_RD_OK]};

endmodule

// File: rtl/flash_ctrl.sv
// Request sequencer for the on-chip user flash: word read, protected word
// write and sector erase, each answered by a single response strobe.
module flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int TO_W           = 21,
    parameter int POLL_GAP       = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] flash_data_addr,
    output logic        flash_data_read,
    output logic        flash_data_write,
    output logic [31:0] flash_data_writedata,
    output logic [1:0]  flash_data_burstcount,
    input  logic [31:0] flash_data_readdata,
    input  logic        flash_data_waitrequest,
    input  logic        flash_data_readdatavalid,
    output logic        flash_csr_addr,
    output logic        flash_csr_read,
    output logic        flash_csr_write,
    output logic [31:0] flash_csr_writedata,
    input  logic [31:0] flash_csr_readdata
);

    state_e      state_reg, state_next;
    logic [1:0]  op_reg, op_next;
    logic [15:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;

    logic poll_start, poll_active, poll_csr_read, poll_done, poll_ok, poll_timeout;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    op_next    = req_op;
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                    err_next   = 1'b0;
                    case (req_op)
                        OP_READ:  state_next = RD_ISSUE;
                        OP_WRITE: state_next = UNLOCK;
                        OP_ERASE: begin
                            if (sector_valid(req_addr[2:0])) begin
                                state_next = ER_CTRL;
                            end else begin
                                err_next   = 1'b1;
                                state_next = DONE;
                            end
                        end
                        default: begin
                            err_next   = 1'b1;
                            state_next = DONE;
                        end
                    endcase
                end
            end
            RD_ISSUE: if (!flash_data_waitrequest) state_next = RD_WAIT;
            RD_WAIT: begin
                if (flash_data_readdatavalid) begin
                    rdata_next = flash_data_readdata;
                    err_next   = 1'b0;
                    state_next = DONE;
                end
            end
            UNLOCK:   state_next = WR_ISSUE;
            WR_ISSUE: if (!flash_data_waitrequest) state_next = POLL;
            ER_CTRL:  state_next = POLL;
            POLL: begin
                // A real status result wins over a timeout landing on the same cycle.
                if (poll_done) begin
                    err_next   = !poll_ok;
                    state_next = LOCK;
                end else if (poll_timeout) begin
                    err_next   = 1'b1;
                    state_next = LOCK;
                end
            end
            LOCK:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign poll_active = (state_reg == POLL);
    assign poll_start  = (state_reg != POLL) && (state_next == POLL);

    flash_status_poller #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W),
        .POLL_GAP       (POLL_GAP)
    ) u_poller (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (poll_start),
        .active       (poll_active),
        .is_erase     (op_reg == OP_ERASE),
        .csr_readdata (flash_csr_readdata),
        .csr_read     (poll_csr_read),
        .done         (poll_done),
        .ok           (poll_ok),
        .timeout      (poll_timeout)
    );

    // All strobes decode from the state register so reset removes them at once.
    always_comb begin
        req_ready             = (state_reg == IDLE);
        flash_data_addr       = addr_reg;
        flash_data_writedata  = wdata_reg;
        flash_data_burstcount = 2'd1;
        flash_data_read       = (state_reg == RD_ISSUE);
        flash_data_write      = (state_reg == WR_ISSUE);
        flash_csr_write       = (state_reg == UNLOCK) || (state_reg == ER_CTRL) || (state_reg == LOCK);
        flash_csr_read        = poll_csr_read;
        flash_csr_addr        = flash_csr_write ? CSR_CONTROL : CSR_STATUS;
        flash_csr_writedata   = '0;
        case (state_reg)
            UNLOCK:  flash_csr_writedata = CTRL_UNLOCK;
            ER_CTRL: flash_csr_writedata = erase_ctrl(addr_reg[2:0]);
            LOCK:    flash_csr_writedata = CTRL_LOCK;
            default: flash_csr_writedata = '0;
        endcase
        rsp_valid = (state_reg == DONE);
        rsp_err   = (state_reg == DONE) && err_reg;
        rsp_rdata = rdata_reg;
    end

endmodule

// File: tb/tb_flash_ctrl.sv
// Directed bench for flash_ctrl with a behavioural flash model on the data
// and CSR ports; each scenario task checks its own expected values.
module tb_flash_ctrl;
    import flash_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] flash_data_addr;
    logic        flash_data_read;
    logic        flash_data_write;
    logic [31:0] flash_data_writedata;
    logic [1:0]  flash_data_burstcount;
    logic [31:0] flash_data_readdata;
    logic        flash_data_waitrequest;
    logic        flash_data_readdatavalid;
    logic        flash_csr_addr;
    logic        flash_csr_read;
    logic        flash_csr_write;
    logic [31:0] flash_csr_writedata;
    logic [31:0] flash_csr_readdata = 32'h0;

    int n_cmp = 0;
    int n_fail = 0;

    flash_ctrl #(
        .TIMEOUT_CYCLES (50),
        .TO_W           (21),
        .POLL_GAP       (3)
    ) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_op                   (req_op),
        .req_addr                 (req_addr),
        .req_wdata                (req_wdata),
        .rsp_valid                (rsp_valid),
        .rsp_rdata                (rsp_rdata),
        .rsp_err                  (rsp_err),
        .flash_data_addr          (flash_data_addr),
        .flash_data_read          (flash_data_read),
        .flash_data_write         (flash_data_write),
        .flash_data_writedata     (flash_data_writedata),
        .flash_data_burstcount    (flash_data_burstcount),
        .flash_data_readdata      (flash_data_readdata),
        .flash_data_waitrequest   (flash_data_waitrequest),
        .flash_data_readdatavalid (flash_data_readdatavalid),
        .flash_csr_addr           (flash_csr_addr),
        .flash_csr_read           (flash_csr_read),
        .flash_csr_write          (flash_csr_write),
        .flash_csr_writedata      (flash_csr_writedata),
        .flash_csr_readdata       (flash_csr_readdata)
    );

    always #5 clock = ~clock;

    // ---------------- flash model ----------------
    int          wait_cfg = 0;
    logic [31:0] rd_value = 32'h0;
    int          busy_polls = 0;
    logic [31:0] idle_status = 32'h0;

    int          wait_left = 0;
    logic        rdv_pending = 1'b0;
    int          dr_count = 0, dw_count = 0, csr_rd_count = 0, csr_wcount = 0;
    int          strobe_cnt = 0, overlap_cnt = 0;
    logic [15:0] dr_addr = 16'h0, dw_addr = 16'h0;
    logic [31:0] dw_data = 32'h0;
    logic [31:0] csr_wlog [0:63];
    logic        csr_alog [0:63];

    assign flash_data_waitrequest   = (flash_data_read || flash_data_write) && (wait_left != 0);
    assign flash_data_readdatavalid = rdv_pending;
    assign flash_data_readdata      = rdv_pending ? rd_value : 32'h0;

    always @(posedge clock) begin
        if (!(flash_data_read || flash_data_write))
            wait_left <= wait_cfg;
        else if (wait_left != 0)
            wait_left <= wait_left - 1;
        rdv_pending <= flash_data_read && !flash_data_waitrequest;
        if (flash_data_read && !flash_data_waitrequest) begin
            dr_count <= dr_count + 1;
            dr_addr  <= flash_data_addr;
        end
        if (flash_data_write && !flash_data_waitrequest) begin
            dw_count <= dw_count + 1;
            dw_addr  <= flash_data_addr;
            dw_data  <= flash_data_writedata;
        end
        if (flash_csr_read) begin
            flash_csr_readdata <= (csr_rd_count < busy_polls) ? 32'h0000_0002 : idle_status;
            csr_rd_count       <= csr_rd_count + 1;
        end
        if (flash_csr_write) begin
            csr_wlog[csr_wcount % 64] <= flash_csr_writedata;
            csr_alog[csr_wcount % 64] <= flash_csr_addr;
            csr_wcount                <= csr_wcount + 1;
        end
    end

    always @(negedge clock) begin
        if (flash_data_read || flash_data_write || flash_csr_read || flash_csr_write)
            strobe_cnt <= strobe_cnt + 1;
        if ((flash_data_read || flash_data_write) && (flash_csr_read || flash_csr_write))
            overlap_cnt <= overlap_cnt + 1;
        if ((flash_data_read && flash_data_write) || (flash_csr_read && flash_csr_write))
            overlap_cnt <= overlap_cnt + 1;
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wdata,
                          output bit got, output int lat, output logic [31:0] rdata,
                          output logic err, output bit ready_after);
        got = 0; lat = 0; rdata = 'x; err = 1'bx; ready_after = 0;
        @(negedge clock);
        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clock);
        for (int i = 1; i <= 2000 && !got; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (rsp_valid) begin
                got = 1; lat = i; rdata = rsp_rdata; err = rsp_err;
            end
        end
        if (got) begin
            @(negedge clock);
            ready_after = req_ready && !rsp_valid;
        end
        #1;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if ({flash_data_read, flash_data_write, flash_csr_read, flash_csr_write} !== 4'b0000)
            begin n_fail++; $display("FAIL reset_strobes: got %b want 0000",
                {flash_data_read, flash_data_write, flash_csr_read, flash_csr_write}); end
        n_cmp++; if (flash_data_burstcount !== 2'd1) begin n_fail++; $display("FAIL reset_burstcount: got %0d want 1", flash_data_burstcount); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
        $display("reset: ready=%b rsp_valid=%b burst=%0d", req_ready, rsp_valid, flash_data_burstcount);
    endtask

    task automatic test_read();
        bit got, rdy; int lat; logic [31:0] rd; logic err;
        int cw0, cr0, dr0;
        cw0 = csr_wcount; cr0 = csr_rd_count; dr0 = dr_count;
        wait_cfg = 2; rd_value = 32'hDEADBEEF;
        do_req(OP_READ, 16'h0123, 32'h0, got, lat, rd, err, rdy);
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL read_rsp: got %b want 1", got); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rdata: got %h want deadbeef", rd); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b want 0", err); end
        n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL read_latency_ws2: got %0d want 5", lat); end
        n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL read_single_pulse: got %b want 1", rdy); end
        n_cmp++; if (dr_count - dr0 != 1 || dr_addr !== 16'h0123)
            begin n_fail++; $display("FAIL read_access: got n=%0d addr=%h want n=1 addr=0123", dr_count - dr0, dr_addr); end
        n_cmp++; if (csr_wcount != cw0 || csr_rd_count != cr0)
            begin n_fail++; $display("FAIL read_no_csr: got w=%0d r=%0d want 0 0", csr_wcount - cw0, csr_rd_count - cr0); end
        $display("read 0123: rdata=%h err=%b lat=%0d", rd, err, lat);

        wait_cfg = 0; rd_value = 32'hCAFE0001;
        do_req(OP_READ, 16'h0007, 32'h0, got, lat, rd, err, rdy);
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL read_min_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'hCAFE0001) begin n_fail++; $display("FAIL read_min_rdata: got %h want cafe0001", rd); end
        $display("read 0007: rdata=%h err=%b lat=%0d", rd, err, lat);
    endtask

    task automatic test_write();
        bit got, rdy; int lat; logic [31:0] rd; logic err;
        int cw0, cr0, dw0;
        cw0 = csr_wcount; cr0 = csr_rd_count; dw0 = dw_count;
        wait_cfg = 1; busy_polls = csr_rd_count + 5; idle_status = 32'h0000_0008;
        do_req(OP_WRITE, 16'h0040, 32'h12345678, got, lat, rd, err, rdy);
        n_cmp++; if (got !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL write_rsp: got rsp=%b err=%b want 1 0", got, err); end
        n_cmp++; if (csr_wcount - cw0 != 2) begin n_fail++; $display("FAIL write_csr_count: got %0d want 2", csr_wcount - cw0); end
        n_cmp++; if (csr_wlog[cw0 % 64] !== 32'hF07FFFFF || csr_alog[cw0 % 64] !== 1'b1)
            begin n_fail++; $display("FAIL write_unlock: got %h@%b want f07fffff@1", csr_wlog[cw0 % 64], csr_alog[cw0 % 64]); end
        n_cmp++; if (csr_wlog[(cw0 + 1) % 64] !== 32'hFFFFFFFF || csr_alog[(cw0 + 1) % 64] !== 1'b1)
            begin n_fail++; $display("FAIL write_lock: got %h@%b want ffffffff@1", csr_wlog[(cw0 + 1) % 64], csr_alog[(cw0 + 1) % 64]); end
        n_cmp++; if (dw_count - dw0 != 1 || dw_addr !== 16'h0040 || dw_data !== 32'h12345678)
            begin n_fail++; $display("FAIL write_data: got n=%0d %h/%h want 1 0040/12345678", dw_count - dw0, dw_addr, dw_data); end
        n_cmp++; if (csr_rd_count - cr0 != 6) begin n_fail++; $display("FAIL write_polls: got %0d want 6", csr_rd_count - cr0); end
        n_cmp++; if (rd !== 32'hCAFE0001) begin n_fail++; $display("FAIL write_rdata_hold: got %h want cafe0001", rd); end
        n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL write_ready_back: got %b want 1", rdy); end
        $display("write 0040=12345678: err=%b polls=%0d lat=%0d", err, csr_rd_count - cr0, lat);
        wait_cfg = 0;
    endtask

    task automatic test_erase();
        bit got, rdy; int lat; logic [31:0] rd; logic err;
        int cw0, dw0, dr0;
        cw0 = csr_wcount; dw0 = dw_count; dr0 = dr_count;
        busy_polls = csr_rd_count; idle_status = 32'h0000_0008;
        do_req(OP_ERASE, 16'h0003, 32'h0, got, lat, rd, err, rdy);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL erase3_err: got %b want 1", err); end
        n_cmp++; if (csr_wlog[cw0 % 64] !== 32'hF03FFFFF) begin n_fail++; $display("FAIL erase3_ctrl: got %h want f03fffff", csr_wlog[cw0 % 64]); end
        n_cmp++; if (csr_wcount - cw0 != 2 || csr_wlog[(cw0 + 1) % 64] !== 32'hFFFFFFFF)
            begin n_fail++; $display("FAIL erase3_lock: got n=%0d %h want 2 ffffffff", csr_wcount - cw0, csr_wlog[(cw0 + 1) % 64]); end
        n_cmp++; if (dw_count != dw0 || dr_count != dr0) begin n_fail++; $display("FAIL erase3_no_data: got w=%0d r=%0d want 0 0", dw_count - dw0, dr_count - dr0); end
        $display("erase sector 3: err=%b ctrl=%h", err, csr_wlog[cw0 % 64]);

        cw0 = csr_wcount;
        busy_polls = csr_rd_count + 1; idle_status = 32'h0000_0010;
        do_req(OP_ERASE, 16'hA005, 32'h0, got, lat, rd, err, rdy);
        n_cmp++; if (got !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL erase5_err: got rsp=%b err=%b want 1 0", got, err); end
        n_cmp++; if (csr_wlog[cw0 % 64] !== 32'hF05FFFFF) begin n_fail++; $display("FAIL erase5_ctrl: got %h want f05fffff", csr_wlog[cw0 % 64]); end
        $display("erase sector 5: err=%b ctrl=%h", err, csr_wlog[cw0 % 64]);
    endtask

    task automatic test_invalid();
        logic [1:0]  ops   [3] = '{2'b10, 2'b11, 2'b10};
        logic [15:0] addrs [3] = '{16'h0008, 16'h0001, 16'h0006};
        bit got, rdy; int lat; logic [31:0] rd; logic err; int s0;
        for (int k = 0; k < 3; k++) begin
            s0 = strobe_cnt;
            do_req(ops[k], addrs[k], 32'h0, got, lat, rd, err, rdy);
            n_cmp++; if (got !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL invalid%0d_err: got rsp=%b err=%b want 1 1", k, got, err); end
            n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL invalid%0d_latency: got %0d want 1", k, lat); end
            n_cmp++; if (strobe_cnt != s0) begin n_fail++; $display("FAIL invalid%0d_strobes: got %0d want 0", k, strobe_cnt - s0); end
            n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL invalid%0d_ready: got %b want 1", k, rdy); end
            $display("invalid op=%b addr=%h: err=%b lat=%0d", ops[k], addrs[k], err, lat);
        end
    endtask

    task automatic test_timeout();
        bit got, rdy; int lat; logic [31:0] rd; logic err; int cw0;
        cw0 = csr_wcount;
        busy_polls = csr_rd_count + 100000;
        do_req(OP_WRITE, 16'h00AA, 32'h0000_0001, got, lat, rd, err, rdy);
        n_cmp++; if (got !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got rsp=%b err=%b want 1 1", got, err); end
        n_cmp++; if (csr_wcount - cw0 != 2 || csr_wlog[(cw0 + 1) % 64] !== 32'hFFFFFFFF)
            begin n_fail++; $display("FAIL timeout_lock: got n=%0d %h want 2 ffffffff", csr_wcount - cw0, csr_wlog[(cw0 + 1) % 64]); end
        n_cmp++; if (lat < 50) begin n_fail++; $display("FAIL timeout_latency: got %0d want >=50", lat); end
        n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL timeout_ready: got %b want 1", rdy); end
        $display("write timeout: err=%b lat=%0d", err, lat);
    endtask

    task automatic test_reset_mid();
        bit seen; bit got, rdy; int lat; logic [31:0] rd; logic err;
        seen = 0;
        busy_polls = csr_rd_count + 100000;
        @(negedge clock);
        req_op = OP_ERASE; req_addr = 16'h0002; req_valid = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (flash_csr_read) seen = 1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL midreset_poll_seen: got %b want 1", seen); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({flash_data_read, flash_data_write, flash_csr_read, flash_csr_write} !== 4'b0000)
            begin n_fail++; $display("FAIL midreset_strobes: got %b want 0000",
                {flash_data_read, flash_data_write, flash_csr_read, flash_csr_write}); end
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
            begin n_fail++; $display("FAIL midreset_rsp: got ready=%b v=%b e=%b d=%h want 1 0 0 0", req_ready, rsp_valid, rsp_err, rsp_rdata); end
        @(negedge clock);
        reset_n = 1'b1;
        wait_cfg = 0; rd_value = 32'h600DF00D;
        do_req(OP_READ, 16'h0055, 32'h0, got, lat, rd, err, rdy);
        n_cmp++; if (got !== 1'b1 || rd !== 32'h600DF00D || err !== 1'b0)
            begin n_fail++; $display("FAIL after_reset_read: got rsp=%b %h err=%b want 1 600df00d 0", got, rd, err); end
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL after_reset_latency: got %0d want 3", lat); end
        $display("reset in poll, then read 0055: rdata=%h err=%b lat=%0d", rd, err, lat);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_erase();
        test_invalid();
        test_timeout();
        test_reset_mid();
        n_cmp++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
